// File: rtl/fa_pipe.sv
// Elastic pipelined adder/subtractor with valid/ready at both ends and STAGES register slots.
// Optional signed saturation of the sum when FA_PIPE_SAT_EN is defined.
module fa_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int MSB = WIDTH - 1;
  localparam int PW  = WIDTH + 2;

  logic [WIDTH-1:0] bx;
  logic             cx;
  logic [WIDTH:0]   sum_full;
  logic             sum_ovf;
  logic [WIDTH-1:0] cap_s;
  logic [PW-1:0]    cap_data;

  assign bx       = sub ? ~b : b;
  assign cx       = sub ? ~c_in : c_in;
  assign sum_full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cx};
  assign sum_ovf  = (a[MSB] == bx[MSB]) && (sum_full[MSB] != a[MSB]);

`ifdef FA_PIPE_SAT_EN
  // Largest positive / most negative value; shift form stays legal for WIDTH == 1.
  localparam logic [WIDTH-1:0] SAT_POS = {WIDTH{1'b1}} >> 1;
  localparam logic [WIDTH-1:0] SAT_NEG = ~SAT_POS;

  assign cap_s = sum_ovf ? (a[MSB] ? SAT_NEG : SAT_POS) : sum_full[MSB:0];
`else
  assign cap_s = sum_full[MSB:0];
`endif

  assign cap_data = {cap_s, sum_full[WIDTH], sum_ovf};

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic          v_reg;
      logic [PW-1:0] data_reg;
      logic          rdy;
      logic          nxt_rdy;
      logic          src_v;
      logic [PW-1:0] src_data;

      // A stage can load when empty or when its content is leaving this cycle.
      assign rdy = !v_reg || nxt_rdy;

      if (gi == 0) begin : g_src
        assign src_v    = in_valid;
        assign src_data = cap_data;
      end else begin : g_src
        assign src_v    = g_stage[gi-1].v_reg;
        assign src_data = g_stage[gi-1].data_reg;
      end

      if (gi == STAGES - 1) begin : g_nxt
        assign nxt_rdy = out_ready;
      end else begin : g_nxt
        assign nxt_rdy = g_stage[gi+1].rdy;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_reg    <= 1'b0;
          data_reg <= '0;
        end else if (rdy) begin
          v_reg <= src_v;
          if (src_v) begin
            data_reg <= src_data;
          end
        end
      end
    end
  endgenerate

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[STAGES-1].v_reg;
  assign s         = g_stage[STAGES-1].data_reg[PW-1:2];
  assign c_out     = g_stage[STAGES-1].data_reg[1];
  assign ovf       = g_stage[STAGES-1].data_reg[0];

endmodule

// File: tb/tb_fa_pipe.sv
// Self-checking bench for fa_pipe (WIDTH=4, STAGES=2) using an arithmetic reference model and a FIFO scoreboard.
module tb_fa_pipe;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic       sub;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] s;
  logic       c_out;
  logic       ovf;
  logic       out_valid;
  logic       out_ready;

  int tests;
  int fails;
  logic [5:0] exp_q[$];

  fa_pipe #(.WIDTH(4), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .s(s), .c_out(c_out),
    .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: signed/unsigned integer arithmetic, result as {s, c_out, ovf}.
  function automatic logic [5:0] model(input int ai, input int bi, input int ci, input int si);
    int u;
    int sa;
    int sb;
    int sr;
    logic [3:0] r;
    logic co;
    logic ov;
    sa = (ai >= 8) ? ai - 16 : ai;
    sb = (bi >= 8) ? bi - 16 : bi;
    if (si != 0) begin
      u  = ai - bi - ci;
      sr = sa - sb - ci;
      co = (u >= 0);
    end else begin
      u  = ai + bi + ci;
      sr = sa + sb + ci;
      co = (u >= 16);
    end
    r  = u[3:0];
    ov = (sr > 7) || (sr < -8);
`ifdef FA_PIPE_SAT_EN
    if (ov) r = (sr > 7) ? 4'h7 : 4'h8;
`endif
    return {r, co, ov};
  endfunction

  // One clock cycle: drive at the negedge, sample 1 time unit later, then advance to the next negedge.
  task automatic step(input logic iv, input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                      input logic tsub, input logic ordy, output logic acc, output logic took,
                      output logic ovld, output logic [5:0] got);
    in_valid  = iv;
    a         = ta;
    b         = tb_;
    c_in      = tc;
    sub       = tsub;
    out_ready = ordy;
    #1;
    acc  = iv && in_ready;
    took = out_valid && ordy;
    ovld = out_valid;
    got  = {s, c_out, ovf};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid = 0; a = 0; b = 0; c_in = 0; sub = 0; out_ready = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    tests++;
    if ({s, c_out, ovf} !== 6'b0) begin fails++; $display("FAIL reset_payload: got %h required 00", {s, c_out, ovf}); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    @(negedge clk);
    $display("[TB] reset checked");
  endtask

  task automatic test_directed();
    logic [3:0] va[5];
    logic [3:0] vb[5];
    logic       vc[5];
    logic       vs[5];
    logic [5:0] ve[5];
    logic acc, took, ovld;
    logic [5:0] got;
    int lat;
    va[0] = 7;  vb[0] = 5; vc[0] = 1; vs[0] = 0;
    va[1] = 3;  vb[1] = 5; vc[1] = 0; vs[1] = 1;
    va[2] = 9;  vb[2] = 2; vc[2] = 1; vs[2] = 1;
    va[3] = 15; vb[3] = 1; vc[3] = 0; vs[3] = 0;
    va[4] = 0;  vb[4] = 8; vc[4] = 0; vs[4] = 1;
`ifdef FA_PIPE_SAT_EN
    ve[0] = {4'h7, 1'b0, 1'b1};
    ve[2] = {4'h8, 1'b1, 1'b1};
    ve[4] = {4'h7, 1'b0, 1'b1};
`else
    ve[0] = {4'hD, 1'b0, 1'b1};
    ve[2] = {4'h6, 1'b1, 1'b1};
    ve[4] = {4'h8, 1'b0, 1'b1};
`endif
    ve[1] = {4'hE, 1'b0, 1'b0};
    ve[3] = {4'h0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, va[i], vb[i], vc[i], vs[i], 1'b1, acc, took, ovld, got);
      tests++;
      if (acc !== 1'b1) begin fails++; $display("FAIL directed_accept[%0d]: got %b required 1", i, acc); end
      lat = 0;
      for (int k = 1; k <= 5 && lat == 0; k++) begin
        step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, acc, took, ovld, got);
        if (took) lat = k;
      end
      tests++;
      if (lat != 2) begin fails++; $display("FAIL directed_latency[%0d]: got %0d idle cycles required 2", i, lat); end
      tests++;
      if (got !== ve[i]) begin fails++; $display("FAIL directed_result[%0d]: got %h required %h", i, got, ve[i]); end
      tests++;
      if (ve[i] !== model(va[i], vb[i], vc[i], vs[i])) begin
        fails++; $display("FAIL directed_model[%0d]: got %h required %h", i, model(va[i], vb[i], vc[i], vs[i]), ve[i]);
      end
      $display("[TB] directed a=%h b=%h c=%b sub=%b -> %h latency %0d", va[i], vb[i], vc[i], vs[i], got, lat);
    end
  endtask

  task automatic test_streaming();
    logic acc, took, ovld;
    logic [5:0] got;
    logic [5:0] e;
    logic [3:0] ra, rb;
    logic rc, rs;
    int n_acc;
    int n_out;
    exp_q.delete();
    n_acc = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));  rs = 1'($urandom_range(0, 1));
      step(cyc < 10, ra, rb, rc, rs, 1'b1, acc, took, ovld, got);
      if (acc) begin exp_q.push_back(model(ra, rb, rc, rs)); n_acc++; end
      if (took) begin
        tests++;
        if (cyc != n_out + 2) begin fails++; $display("FAIL stream_timing: got output %0d at cycle %0d required cycle %0d", n_out, cyc, n_out + 2); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3F;
        tests++;
        if (got !== e) begin fails++; $display("FAIL stream_result[%0d]: got %h required %h", n_out, got, e); end
        $display("[TB] stream out %0d = %h", n_out, got);
        n_out++;
      end
    end
    tests++;
    if (n_acc != 10) begin fails++; $display("FAIL stream_accepts: got %0d required 10", n_acc); end
    tests++;
    if (n_out != 10) begin fails++; $display("FAIL stream_outputs: got %0d required 10", n_out); end
  endtask

  task automatic test_backpressure();
    logic [3:0] oa[4];
    logic [3:0] ob[4];
    logic       oc[4];
    logic       os[4];
    logic acc, took, ovld;
    logic [5:0] got;
    logic [5:0] held;
    logic [5:0] e;
    logic have_held;
    int idx;
    int n_out;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      oa[i] = 4'($urandom_range(0, 15)); ob[i] = 4'($urandom_range(0, 15));
      oc[i] = 1'($urandom_range(0, 1));  os[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    have_held = 0;
    held = '0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      step(1'b1, oa[idx], ob[idx], oc[idx], os[idx], 1'b0, acc, took, ovld, got);
      if (acc) begin exp_q.push_back(model(oa[idx], ob[idx], oc[idx], os[idx])); idx++; end
      if (ovld && !have_held) begin held = got; have_held = 1; end
      else if (ovld) begin
        tests++;
        if (got !== held) begin fails++; $display("FAIL bp_hold: got %h required %h", got, held); end
      end
    end
    tests++;
    if (idx != 2) begin fails++; $display("FAIL bp_accepted: got %0d required 2", idx); end
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
    $display("[TB] backpressure accepted %0d, held %h", idx, held);
    n_out = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (idx < 4) step(1'b1, oa[idx], ob[idx], oc[idx], os[idx], 1'b1, acc, took, ovld, got);
      else         step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, acc, took, ovld, got);
      if (acc) begin exp_q.push_back(model(oa[idx], ob[idx], oc[idx], os[idx])); idx++; end
      if (took) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3F;
        tests++;
        if (got !== e) begin fails++; $display("FAIL bp_result[%0d]: got %h required %h", n_out, got, e); end
        $display("[TB] backpressure out %0d = %h", n_out, got);
        n_out++;
      end
    end
    tests++;
    if (n_out != 4) begin fails++; $display("FAIL bp_outputs: got %0d required 4", n_out); end
  endtask

  task automatic test_reset_midflight();
    logic acc, took, ovld;
    logic [5:0] got;
    int n_acc;
    int stale;
    exp_q.delete();
    n_acc = 0;
    for (int cyc = 0; cyc < 4 && n_acc < 2; cyc++) begin
      step(1'b1, 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0, acc, took, ovld, got);
      if (acc) n_acc++;
    end
    in_valid = 0;
    #1;
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL midrst_before: got out_valid %b required 1", out_valid); end
    #1 rst = 1;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
    tests++;
    if (s !== 4'h0) begin fails++; $display("FAIL midrst_s: got %h required 0", s); end
    @(negedge clk);
    rst = 0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b required 1", in_ready); end
    stale = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, acc, took, ovld, got);
      if (ovld) stale++;
    end
    tests++;
    if (stale != 0) begin fails++; $display("FAIL midrst_stale: got %0d stale results required 0", stale); end
    $display("[TB] reset mid-flight flushed %0d results", n_acc);
  endtask

  task automatic test_random();
    logic acc, took, ovld;
    logic [5:0] got;
    logic [5:0] e;
    logic [3:0] ra, rb;
    logic rc, rs, iv, ordy;
    int n_out;
    exp_q.delete();
    n_out = 0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));  rs = 1'($urandom_range(0, 1));
      iv   = (cyc < 300) && ($urandom_range(0, 3) != 0);
      ordy = (cyc >= 300) || ($urandom_range(0, 2) != 0);
      step(iv, ra, rb, rc, rs, ordy, acc, took, ovld, got);
      if (acc) exp_q.push_back(model(ra, rb, rc, rs));
      if (took) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3F;
        tests++;
        if (got !== e) begin fails++; $display("FAIL random_result[%0d]: got %h required %h", n_out, got, e); end
        n_out++;
      end
    end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL random_drain: got %0d pending required 0", exp_q.size()); end
    $display("[TB] random traffic delivered %0d results", n_out);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_streaming();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fa_pipe.md
# fa_pipe

Parametrised, elastic pipelined adder/subtractor: the next generation of the team's fixed 2-bit, fixed 2-stage full adder. Operand width, pipeline depth and add/sub mode are generalised. A valid/ready handshake is added at both ends, so upstream stalls and downstream backpressure never lose or duplicate results. It sits between an operand producer and a result consumer in datapath benches and the assertion training suite.

## Interface
- `WIDTH`, default 4: operand and sum width in bits; must be ≥ 1.
- `STAGES`, default 2: register stages between operand capture and the result; must be ≥ 1.

- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `a`  input  WIDTH: operand A.
- `b`  input  WIDTH: operand B.
- `c_in`  input  1: carry-in in add mode, borrow-in in sub mode.
- `sub`  input  1: 0 selects add, 1 selects subtract.
- `in_valid`  input  1: operands and mode are valid this cycle.
- `in_ready`  output  1: the block accepts operands this cycle.
- `s`  output  WIDTH: result.
- `c_out`  output  1: carry-out; in sub mode, 1 means no borrow.
- `ovf`  output  1: two's-complement overflow of the result.
- `out_valid`  output  1: `s`, `c_out` and `ovf` are valid.
- `out_ready`  input  1: the consumer accepts the result this cycle.

## Operation
- Arithmetic is combinational on the input side, evaluated before stage 1:
  - Define `bx = sub ? ~b : b` and `cx = sub ? ~c_in : c_in`.
  - `{c_out, s} = a + bx + cx`, computed at WIDTH+1 bits. In sub mode this equals a − b − c_in.
  - `ovf = (a[MSB] == bx[MSB]) && (s[MSB] != a[MSB])`.
- Each of the STAGES stages holds `v[k]` plus the payload {s, c_out, ovf}. The last stage drives the outputs directly.
- Advance rules:
  - Stage k loads from stage k−1 when `!v[k]`, or when stage k+1 (or the output port, for the last stage) takes stage k's content in the same cycle.
  - Stage 1 loads from the input when `in_valid && in_ready`.
- `in_ready = !v[1] || stage1_advances`. This is a combinational ready chain back from `out_ready`.
- A stage whose content moves on and that receives nothing clears its `v`. Its payload is don't-care, but a cleared stage must not be reported valid.
- Ordering is strict FIFO. Capacity is STAGES results.
- Handshake rules:
  - A transfer occurs on a clock edge where valid && ready.
  - While `out_valid && !out_ready`, `s`, `c_out` and `ovf` hold stable.
  - `in_valid` may drop without a completed transfer; nothing is captured in that case.

## Timing
- Reset values: all `v[k]` = 0 and all payload = 0. Therefore `out_valid`=0, `s`=0, `c_out`=0, `ovf`=0, and `in_ready`=1 while `rst` is low and the pipeline is empty.
- Asserting `rst` mid-operation flushes all in-flight results asynchronously. `out_valid` falls without waiting for a clock edge.
- The first accepting edge after `rst` deasserts may capture operands.
- Latency: operands accepted at edge N appear with `out_valid`=1 after edge N+STAGES−1. They are visible in the cycle following that edge, i.e. after STAGES edges counting the capture edge.
- Throughput: one result per cycle while `out_ready`=1.
- Full: all `v[k]`=1 and `out_ready`=0 gives `in_ready`=0.
- Simultaneous output take and input accept on a full pipeline is allowed; the pipeline stays full with no bubble.
- Wrap-around is modulo 2^WIDTH, with the carry reported on `c_out`.

## Configuration
- `FA_PIPE_SAT_EN` defined:
  - When `ovf`=1, `s` is replaced at stage-1 capture with signed saturation: 0 followed by WIDTH−1 ones if `a[MSB]`=0, otherwise 1 followed by WIDTH−1 zeros.
  - `c_out` and `ovf` are reported unchanged.
- Not defined: `s` is always the wrapped sum and no saturation logic is present.

## Test plan
Parameters for all scenarios: WIDTH=4, STAGES=2.

- **Add with signed overflow:** a=7, b=5, c_in=1, sub=0 → s=4'hD, c_out=0, ovf=1. With `FA_PIPE_SAT_EN`, s=4'h7.
- **Subtract:** a=3, b=5, c_in=0, sub=1 → s=4'hE, c_out=0, ovf=0. Then a=9, b=2, c_in=1, sub=1 → s=4'h6, c_out=1, ovf=1. With `FA_PIPE_SAT_EN`, the second result is s=4'h8.
- **Unsigned wrap:** a=F, b=1, c_in=0, sub=0 → s=0, c_out=1, ovf=0.
- **Full-rate streaming:** `out_ready`=1 and `in_valid` held high for 10 random operand sets → each result appears after the 2-edge latency, one per cycle, in order, matching a scoreboard.
- **Backpressure:** `out_ready`=0 while offering 4 operand sets.
  - Exactly 2 sets are accepted, then `in_ready`=0 and the output holds stable.
  - After raising `out_ready`, all 4 results emerge in order with no loss or duplication.
- **Reset mid-flight:** assert `rst` asynchronously with 2 results in flight → `out_valid`=0 and `s`=0 immediately, before the next edge, and `in_ready`=1 after deassertion. No stale result ever appears.
